// File: rtl/regfile_mbist_ctrl.sv
// March C- BIST sequencer for the register file's 1RW test port.
// Walks addresses 0..N-1 (the all-ones address maps to read-only register 0),
// checks read data one cycle after each read and records the first failure.
module regfile_mbist_ctrl #(
    parameter int unsigned           ADDR_WIDTH   = 5,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BG_PATTERN   = '0,
    parameter bit                    STOP_ON_FAIL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [7:0]            fail_cnt_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [2:0]            fail_elem_o,
    output logic [DATA_WIDTH-1:0] fail_data_o,
    output logic                  BIST,
    output logic                  CSN_T,
    output logic                  WEN_T,
    output logic [ADDR_WIDTH-1:0] A_T,
    output logic [DATA_WIDTH-1:0] D_T,
    input  logic [DATA_WIDTH-1:0] Q_T
);

    localparam int unsigned   IW        = ADDR_WIDTH - 1;
    localparam int unsigned   N         = (1 << IW) - 1;
    localparam logic [IW-1:0] IDX_FIRST = '0;
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

    typedef enum logic [3:0] {
        IDLE,
        E0_W0,
        E1_R0W1_UP,
        E2_R1W0_UP,
        E3_R0W1_DN,
        E4_R1W0_DN,
        E5_R0,
        DRAIN,
        DONE
    } state_t;

    state_t                  state;
    logic [IW-1:0]           idx;
    logic                    phase;      // 0 = read half, 1 = write half (E1..E4)
    logic                    csn_q;

    // issued-read tags, then the compare stage one cycle later
    logic [DATA_WIDTH-1:0]   iss_exp;
    logic [2:0]              iss_elem;
    logic                    cmp_vld;
    logic [DATA_WIDTH-1:0]   cmp_exp;
    logic [2:0]              cmp_elem;
    logic [ADDR_WIDTH-1:0]   cmp_addr;

    logic                    miscmp;
    logic [7:0]              fail_cnt_nxt;

    // per-element decode
    logic [2:0]              el_num;
    logic [DATA_WIDTH-1:0]   el_exp;
    logic                    el_up;
    state_t                  el_next;
    logic                    el_last;
    state_t                  state_adv;
    logic [IW-1:0]           idx_adv;

    // Compare the read data returned this cycle and compute the next fail count
    always_comb begin
        miscmp       = cmp_vld && (Q_T != cmp_exp);
        fail_cnt_nxt = fail_cnt_o;
        if (miscmp && (fail_cnt_o != 8'hFF)) begin
            fail_cnt_nxt = fail_cnt_o + 8'd1;
        end
    end

    // With stop-on-fail, the access already on the port during the failing
    // compare cycle is suppressed here; the registered chip select cannot
    // know about the miscompare in time.
    assign CSN_T = csn_q | (STOP_ON_FAIL && miscmp);

    // Element decode: expected read value, direction, successor, next address
    always_comb begin
        el_num  = 3'd0;
        el_exp  = BG_PATTERN;
        el_up   = 1'b1;
        el_next = IDLE;
        case (state)
            E0_W0:      begin el_num = 3'd0; el_exp =  BG_PATTERN; el_up = 1'b1; el_next = E1_R0W1_UP; end
            E1_R0W1_UP: begin el_num = 3'd1; el_exp =  BG_PATTERN; el_up = 1'b1; el_next = E2_R1W0_UP; end
            E2_R1W0_UP: begin el_num = 3'd2; el_exp = ~BG_PATTERN; el_up = 1'b1; el_next = E3_R0W1_DN; end
            E3_R0W1_DN: begin el_num = 3'd3; el_exp =  BG_PATTERN; el_up = 1'b0; el_next = E4_R1W0_DN; end
            E4_R1W0_DN: begin el_num = 3'd4; el_exp = ~BG_PATTERN; el_up = 1'b0; el_next = E5_R0;      end
            E5_R0:      begin el_num = 3'd5; el_exp =  BG_PATTERN; el_up = 1'b1; el_next = DRAIN;      end
            default:    begin el_num = 3'd0; el_exp =  BG_PATTERN; el_up = 1'b1; el_next = IDLE;       end
        endcase
        el_last   = el_up ? (idx == IDX_LAST) : (idx == IDX_FIRST);
        state_adv = state;
        idx_adv   = el_up ? idx + 1'b1 : idx - 1'b1;
        if (el_last) begin
            state_adv = el_next;
            idx_adv   = ((el_next == E3_R0W1_DN) || (el_next == E4_R1W0_DN)) ? IDX_LAST : IDX_FIRST;
        end
    end

    // Sequencer FSM with registered test-port and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            phase       <= 1'b0;
            csn_q       <= 1'b1;
            WEN_T       <= 1'b1;
            A_T         <= '0;
            D_T         <= '0;
            BIST        <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            fail_cnt_o  <= '0;
            fail_addr_o <= '0;
            fail_elem_o <= '0;
            fail_data_o <= '0;
            iss_exp     <= '0;
            iss_elem    <= '0;
            cmp_vld     <= 1'b0;
            cmp_exp     <= '0;
            cmp_elem    <= '0;
            cmp_addr    <= '0;
        end else begin
            cmp_vld  <= !CSN_T && WEN_T;
            cmp_exp  <= iss_exp;
            cmp_elem <= iss_elem;
            cmp_addr <= A_T;

            fail_cnt_o <= fail_cnt_nxt;
            if (miscmp && (fail_cnt_o == 8'd0)) begin
                fail_addr_o <= cmp_addr;
                fail_elem_o <= cmp_elem;
                fail_data_o <= Q_T;
            end

            case (state)
                IDLE, DONE: begin
                    csn_q  <= 1'b1;
                    WEN_T  <= 1'b1;
                    BIST   <= 1'b0;
                    busy_o <= 1'b0;
                    if (state == DONE) begin
                        done_o <= 1'b1;
                        pass_o <= (fail_cnt_nxt == 8'd0);
                    end
                    if (start_i) begin
                        state       <= E0_W0;
                        idx         <= IDX_FIRST;
                        phase       <= 1'b0;
                        BIST        <= 1'b1;
                        busy_o      <= 1'b1;
                        done_o      <= 1'b0;
                        pass_o      <= 1'b0;
                        fail_cnt_o  <= '0;
                        fail_addr_o <= '0;
                        fail_elem_o <= '0;
                        fail_data_o <= '0;
                    end
                end
                E0_W0, E5_R0: begin
                    csn_q    <= 1'b0;
                    A_T      <= {1'b0, idx};
                    WEN_T    <= (state == E5_R0);
                    if (state == E0_W0) begin
                        D_T <= BG_PATTERN;
                    end
                    iss_exp  <= el_exp;
                    iss_elem <= el_num;
                    state    <= state_adv;
                    idx      <= idx_adv;
                end
                E1_R0W1_UP, E2_R1W0_UP, E3_R0W1_DN, E4_R1W0_DN: begin
                    csn_q <= 1'b0;
                    A_T   <= {1'b0, idx};
                    if (!phase) begin
                        WEN_T    <= 1'b1;
                        iss_exp  <= el_exp;
                        iss_elem <= el_num;
                        phase    <= 1'b1;
                    end else begin
                        WEN_T <= 1'b0;
                        D_T   <= ~el_exp;
                        phase <= 1'b0;
                        state <= state_adv;
                        idx   <= idx_adv;
                    end
                end
                DRAIN: begin
                    csn_q <= 1'b1;
                    WEN_T <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (STOP_ON_FAIL && miscmp) begin
                state  <= DONE;
                csn_q  <= 1'b1;
                WEN_T  <= 1'b1;
                BIST   <= 1'b0;
                busy_o <= 1'b0;
                done_o <= 1'b1;
                pass_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mbist_ctrl.sv
// Directed bench: two sequencers (run-to-end and stop-on-fail) each driving
// a small behavioural register-file model with injectable faults.
module tb_regfile_mbist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start;
    logic stuck_en, alias_en;

    logic        busy0, done0, pass0, bist0, csn0, wen0;
    logic [7:0]  cnt0;
    logic [4:0]  faddr0, a0;
    logic [2:0]  felem0;
    logic [31:0] fdata0, d0, q0;

    logic        busy1, done1, pass1, bist1, csn1, wen1;
    logic [7:0]  cnt1;
    logic [4:0]  faddr1, a1;
    logic [2:0]  felem1;
    logic [31:0] fdata1, d1, q1;

    logic [31:0] mem0 [0:31];
    logic [31:0] mem1 [0:31];

    int errors = 0;
    int checks = 0;
    int acc0, acc1, badaddr;
    int dn, dn1;

    regfile_mbist_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BG_PATTERN(32'h0000_0000), .STOP_ON_FAIL(1'b0)) dut (
        .clk(clk), .rst(rst), .start_i(start),
        .busy_o(busy0), .done_o(done0), .pass_o(pass0), .fail_cnt_o(cnt0),
        .fail_addr_o(faddr0), .fail_elem_o(felem0), .fail_data_o(fdata0),
        .BIST(bist0), .CSN_T(csn0), .WEN_T(wen0), .A_T(a0), .D_T(d0), .Q_T(q0)
    );

    regfile_mbist_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BG_PATTERN(32'h0000_0000), .STOP_ON_FAIL(1'b1)) dut_stop (
        .clk(clk), .rst(rst), .start_i(start),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .fail_cnt_o(cnt1),
        .fail_addr_o(faddr1), .fail_elem_o(felem1), .fail_data_o(fdata1),
        .BIST(bist1), .CSN_T(csn1), .WEN_T(wen1), .A_T(a1), .D_T(d1), .Q_T(q1)
    );

    // Register-file models: 1-cycle read latency, stuck-at-1 on bit 7 of word 3,
    // and a decoder alias where a write to 2 also lands in 5.
    initial begin
        q0 = '0;
        q1 = '0;
        for (int i = 0; i < 32; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (!csn0) begin
            if (!wen0) begin
                mem0[a0] <= d0;
                if (alias_en && a0 == 5'd2) mem0[5'd5] <= d0;
            end else begin
                q0 <= mem0[a0] | ((stuck_en && a0 == 5'd3) ? 32'h0000_0080 : 32'h0);
            end
        end
    end

    always @(posedge clk) begin
        if (!csn1) begin
            if (!wen1) begin
                mem1[a1] <= d1;
                if (alias_en && a1 == 5'd2) mem1[5'd5] <= d1;
            end else begin
                q1 <= mem1[a1] | ((stuck_en && a1 == 5'd3) ? 32'h0000_0080 : 32'h0);
            end
        end
    end

    always @(negedge clk) begin
        if (!csn0) acc0++;
        if (!csn1) acc1++;
        if (!csn0 && a0[3:0] == 4'hF) badaddr++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start, optionally pulse it again mid-run, and wait (bounded) for done.
    task automatic run_bist(input int pulse_at, output int done_at, output int done1_at);
        int n;
        acc0 = 0;
        acc1 = 0;
        badaddr = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("clr_done",  {31'b0, done0}, 32'd0);
        check("clr_cnt",   {24'b0, cnt0},  32'd0);
        check("clr_faddr", {27'b0, faddr0}, 32'd0);
        check("clr_felem", {29'b0, felem0}, 32'd0);
        check("clr_fdata", fdata0, 32'd0);
        n = 0;
        done_at = -1;
        done1_at = -1;
        while (done_at < 0 && n < 400) begin
            @(negedge clk);
            start = (n == pulse_at);
            @(posedge clk);
            n++;
            #1;
            if (done0 && done_at < 0) done_at = n;
            if (done1 && done1_at < 0) done1_at = n;
        end
        start = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stuck_en = 1'b0;
        alias_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bist",  {31'b0, bist0}, 32'd0);
        check("rst_csn",   {31'b0, csn0},  32'd1);
        check("rst_wen",   {31'b0, wen0},  32'd1);
        check("rst_a",     {27'b0, a0},    32'd0);
        check("rst_d",     d0,             32'd0);
        check("rst_busy",  {31'b0, busy0}, 32'd0);
        check("rst_done",  {31'b0, done0}, 32'd0);
        check("rst_pass",  {31'b0, pass0}, 32'd0);
        check("rst_cnt",   {24'b0, cnt0},  32'd0);
        check("rst_faddr", {27'b0, faddr0}, 32'd0);
        check("rst_felem", {29'b0, felem0}, 32'd0);
        check("rst_fdata", fdata0,         32'd0);
        @(negedge clk);
        rst = 1'b0;

        // fault-free march
        run_bist(-1, dn, dn1);
        check("clean_done_cyc", dn, 32'd152);
        check("clean_pass",  {31'b0, pass0}, 32'd1);
        check("clean_cnt",   {24'b0, cnt0},  32'd0);
        check("clean_access", acc0, 32'd150);
        check("clean_no_reg0", badaddr, 32'd0);
        check("clean_busy",  {31'b0, busy0}, 32'd0);
        check("clean_bist",  {31'b0, bist0}, 32'd0);
        check("clean_stop_done_cyc", dn1, 32'd152);
        check("clean_stop_pass", {31'b0, pass1}, 32'd1);

        // stuck-at-1 on bit 7 of word 3
        stuck_en = 1'b1;
        run_bist(-1, dn, dn1);
        check("stuck_done_cyc", dn, 32'd152);
        check("stuck_pass",  {31'b0, pass0}, 32'd0);
        check("stuck_cnt",   {24'b0, cnt0},  32'd3);
        check("stuck_faddr", {27'b0, faddr0}, 32'd3);
        check("stuck_felem", {29'b0, felem0}, 32'd1);
        check("stuck_fdata", fdata0, 32'h0000_0080);
        check("stop_done_cyc", dn1, 32'd24);
        check("stop_cnt",    {24'b0, cnt1},  32'd1);
        check("stop_access", acc1, 32'd22);
        check("stop_pass",   {31'b0, pass1}, 32'd0);
        check("stop_faddr",  {27'b0, faddr1}, 32'd3);
        check("stop_bist",   {31'b0, bist1}, 32'd0);
        stuck_en = 1'b0;

        // decoder alias: write to 2 also hits 5
        alias_en = 1'b1;
        run_bist(-1, dn, dn1);
        check("alias_faddr", {27'b0, faddr0}, 32'd5);
        check("alias_felem", {29'b0, felem0}, 32'd1);
        check("alias_fdata", fdata0, 32'hFFFF_FFFF);
        check("alias_pass",  {31'b0, pass0}, 32'd0);
        alias_en = 1'b0;

        // start pulse in the middle of a run is ignored
        run_bist(40, dn, dn1);
        check("midstart_done_cyc", dn, 32'd152);
        check("midstart_pass", {31'b0, pass0}, 32'd1);

        // synchronous reset at cycle 70, then a clean restart
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (69) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_bist", {31'b0, bist0}, 32'd0);
        check("midrst_csn",  {31'b0, csn0},  32'd1);
        check("midrst_busy", {31'b0, busy0}, 32'd0);
        check("midrst_wen",  {31'b0, wen0},  32'd1);
        check("midrst_a",    {27'b0, a0},    32'd0);
        check("midrst_d",    d0,             32'd0);
        check("midrst_done", {31'b0, done0}, 32'd0);
        check("midrst_bist_stop", {31'b0, bist1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_bist(-1, dn, dn1);
        check("restart_done_cyc", dn, 32'd152);
        check("restart_pass", {31'b0, pass0}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
